// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: vertical/horizontal bars, checkerboard and rotating bars.
// Define LCD_PATTERN_BORDER_EN to force a one-pixel white border in every mode.
module lcd_pattern_gen #(
    parameter int unsigned NUM_BARS      = 5,
    parameter int unsigned COLOR_W       = 16,
    parameter int unsigned CELL_LOG2     = 5,
    parameter int unsigned SCROLL_FRAMES = 30
) (
    input  logic               lcd_pclk,
    input  logic               rst,
    input  logic               data_req,
    input  logic [10:0]        pixel_xpos,
    input  logic [10:0]        pixel_ypos,
    input  logic [10:0]        h_disp,
    input  logic [10:0]        v_disp,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] pixel_data,
    output logic               cfg_busy,
    output logic [1:0]         mode_active
);
    localparam int unsigned POS_W   = 11;
    localparam int unsigned BND_W   = POS_W + 1;
    localparam int unsigned REM_W   = 4;
    localparam int unsigned TRIAL_W = REM_W + 1;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned K_W     = 3;
    localparam int unsigned CNT_W   = $clog2(SCROLL_FRAMES + 1);

    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(POS_W - 1);
    localparam logic [K_W-1:0]     K_MAX     = K_W'(NUM_BARS - 1);
    localparam logic [TRIAL_W-1:0] DIVISOR   = TRIAL_W'(NUM_BARS);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCROLL_FRAMES - 1);

`ifdef LCD_PATTERN_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_DIV_H, ST_DIV_V, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [POS_W-1:0]    quo_q, quo_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [POS_W-1:0]    h_lat_q, h_lat_d, v_lat_q, v_lat_d;
    logic [POS_W-1:0]    bar_w_q, bar_w_d, bar_h_q, bar_h_d;
    logic [K_W-1:0]      kv_q, kv_d, kh_q, kh_d;
    logic [BND_W-1:0]    bndv_q, bndv_d, bndh_q, bndh_d;
    logic [1:0]          mode_active_q, mode_active_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [K_W-1:0]      rot_q, rot_d;
    logic [COLOR_W-1:0]  pixel_q, pixel_d;
    logic                cfg_busy_q, cfg_busy_d;

    logic                busy_c, div_h_c, first_step_c, changed_c, restart_c;
    logic [POS_W-1:0]    dividend_c, quo_next_c;
    logic [REM_W-1:0]    rem_src_c, rem_next_c;
    logic [TRIAL_W-1:0]  trial_c;
    logic                ge_c, frame_start_c, on_border_c;
    logic [1:0]          mode_eff_c;
    logic [K_W-1:0]      idx_c;

    function automatic logic [COLOR_W-1:0] palette(input logic [K_W-1:0] idx);
        logic r, g, b;
        case (idx)
            3'd0:    {r, g, b} = 3'b111;
            3'd1:    {r, g, b} = 3'b000;
            3'd2:    {r, g, b} = 3'b100;
            3'd3:    {r, g, b} = 3'b010;
            3'd4:    {r, g, b} = 3'b001;
            3'd5:    {r, g, b} = 3'b110;
            3'd6:    {r, g, b} = 3'b011;
            default: {r, g, b} = 3'b101;
        endcase
        if (COLOR_W == 24) palette = COLOR_W'({{8{r}}, {8{g}}, {8{b}}});
        else               palette = COLOR_W'({{5{r}}, {6{g}}, {5{b}}});
    endfunction

    assign first_step_c = (step_q == '0);
    assign changed_c    = (h_disp != h_lat_q) || (v_disp != v_lat_q);
    // The latch is refreshed on DIV_H step 0, so a mismatch there is not a change.
    assign restart_c    = changed_c &&
                          ((state_q == ST_DIV_H && !first_step_c) || state_q == ST_DIV_V);

    // One restoring-divide step: step 0 takes its dividend straight from the source.
    assign dividend_c = !first_step_c ? quo_q : (div_h_c ? h_disp : v_lat_q);
    assign rem_src_c  = first_step_c ? '0 : rem_q;
    assign trial_c    = {rem_src_c, dividend_c[POS_W-1]};
    assign ge_c       = (trial_c >= DIVISOR);
    assign rem_next_c = ge_c ? REM_W'(trial_c - DIVISOR) : trial_c[REM_W-1:0];
    assign quo_next_c = {dividend_c[POS_W-2:0], ge_c};

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) state_q <= ST_DIV_H;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DIV_H: begin
                if (restart_c)                state_d = ST_DIV_H;
                else if (step_q == LAST_STEP) state_d = ST_DIV_V;
            end
            ST_DIV_V: begin
                if (restart_c)                state_d = ST_DIV_H;
                else if (step_q == LAST_STEP) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (h_disp == '0)   state_d = ST_IDLE;
                else if (changed_c) state_d = ST_DIV_H;
            end
            default: begin
                if (h_disp != '0) state_d = ST_DIV_H;
            end
        endcase
    end

    always_comb begin
        busy_c  = 1'b0;
        div_h_c = 1'b0;
        case (state_q)
            ST_DIV_H: begin
                busy_c  = 1'b1;
                div_h_c = 1'b1;
            end
            ST_DIV_V: busy_c = 1'b1;
            default:  ;
        endcase
    end

    // Geometry divider, boundary counters, rotation and pixel colour.
    always_comb begin
        step_d        = step_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        h_lat_d       = h_lat_q;
        v_lat_d       = v_lat_q;
        bar_w_d       = bar_w_q;
        bar_h_d       = bar_h_q;
        kv_d          = kv_q;
        bndv_d        = bndv_q;
        kh_d          = kh_q;
        bndh_d        = bndh_q;
        frame_cnt_d   = frame_cnt_q;
        rot_d         = rot_q;
        pixel_d       = pixel_q;
        cfg_busy_d    = busy_c;
        idx_c         = '0;

        if (state_d != state_q || restart_c) step_d = '0;
        else if (busy_c)                     step_d = step_q + STEP_W'(1);

        if (busy_c && !restart_c) begin
            quo_d = quo_next_c;
            rem_d = rem_next_c;
            if (div_h_c && first_step_c) begin
                h_lat_d = h_disp;
                v_lat_d = v_disp;
            end
            if (step_q == LAST_STEP) begin
                if (div_h_c) bar_w_d = quo_next_c;
                else         bar_h_d = quo_next_c;
            end
        end

        if (pixel_xpos == '0) begin
            kv_d   = '0;
            bndv_d = BND_W'(bar_w_q);
        end
        if (bar_w_q != '0 && kv_d < K_MAX && BND_W'(pixel_xpos) >= bndv_d) begin
            kv_d   = kv_d + K_W'(1);
            bndv_d = bndv_d + BND_W'(bar_w_q);
        end

        if (pixel_xpos == '0) begin
            if (pixel_ypos == '0) begin
                kh_d   = '0;
                bndh_d = BND_W'(bar_h_q);
            end
            if (bar_h_q != '0 && kh_d < K_MAX && BND_W'(pixel_ypos) >= bndh_d) begin
                kh_d   = kh_d + K_W'(1);
                bndh_d = bndh_d + BND_W'(bar_h_q);
            end
        end

        if (mode_eff_c != 2'd3) begin
            frame_cnt_d = '0;
            rot_d       = '0;
        end else if (frame_start_c && mode_active_q == 2'd3) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                rot_d       = rot_q + K_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end

        case (mode_eff_c)
            2'd0:    idx_c = kv_d;
            2'd1:    idx_c = kh_d;
            2'd2:    idx_c = (pixel_xpos[CELL_LOG2] ^ pixel_ypos[CELL_LOG2]) ? 3'd0 : 3'd1;
            default: idx_c = kv_d + rot_d;
        endcase
        if (BORDER_EN && on_border_c) idx_c = '0;

        if (data_req) pixel_d = cfg_busy_q ? '0 : palette(idx_c);
    end

    assign frame_start_c = data_req && pixel_xpos == '0 && pixel_ypos == '0;
    assign mode_eff_c    = frame_start_c ? mode : mode_active_q;
    assign mode_active_d = mode_eff_c;
    assign on_border_c   = pixel_xpos == '0 || pixel_ypos == '0 ||
                           pixel_xpos == h_disp - POS_W'(1) || pixel_ypos == v_disp - POS_W'(1);

    // Boundary counters only move on a request; the rest tracks every cycle.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            step_q        <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            h_lat_q       <= '0;
            v_lat_q       <= '0;
            bar_w_q       <= '0;
            bar_h_q       <= '0;
            kv_q          <= '0;
            bndv_q        <= '0;
            kh_q          <= '0;
            bndh_q        <= '0;
            mode_active_q <= '0;
            frame_cnt_q   <= '0;
            rot_q         <= '0;
            pixel_q       <= '0;
            cfg_busy_q    <= 1'b1;
        end else begin
            step_q      <= step_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            h_lat_q     <= h_lat_d;
            v_lat_q     <= v_lat_d;
            bar_w_q     <= bar_w_d;
            bar_h_q     <= bar_h_d;
            cfg_busy_q  <= cfg_busy_d;
            pixel_q     <= pixel_d;
            if (data_req) begin
                kv_q          <= kv_d;
                bndv_q        <= bndv_d;
                kh_q          <= kh_d;
                bndh_q        <= bndh_d;
                mode_active_q <= mode_active_d;
                frame_cnt_q   <= frame_cnt_d;
                rot_q         <= rot_d;
            end
        end
    end

    assign pixel_data  = pixel_q;
    assign cfg_busy    = cfg_busy_q;
    assign mode_active = mode_active_q;

endmodule

// File: doc/lcd_pattern_gen.md
# lcd_pattern_gen

Parametrised LCD test-pattern generator: the next generation of the fixed five-bar colour generator. It produces vertical bars, horizontal bars, checkerboard or colour-rotating bars, with a configurable bar count and colour format. Bar geometry comes from an internal sequential divider, so the pixel path has no combinational divide. It sits between the LCD timing driver, which supplies pixel coordinates and requests, and the LCD output mux.

## Interface

Parameters:
- NUM_BARS, 5: number of bars. Legal range 2..8.
- COLOR_W, 16: pixel width. 16 = RGB565, 24 = RGB888. No other values are legal.
- CELL_LOG2, 5: checkerboard cell size is 2^CELL_LOG2 pixels square.
- SCROLL_FRAMES, 30: frames per palette rotation step in mode 3. Legal range ≥1.

Ports:
- lcd_pclk, in, 1: pixel clock. This is the only clock.
- rst, in, 1: reset, asynchronous, active-high.
- data_req, in, 1: driver requests the pixel at (pixel_xpos, pixel_ypos).
- pixel_xpos, in, 11: current pixel column.
- pixel_ypos, in, 11: current pixel row.
- h_disp, in, 11: horizontal resolution.
- v_disp, in, 11: vertical resolution.
- mode, in, 2: requested pattern. 0 = vertical bars, 1 = horizontal bars, 2 = checkerboard, 3 = rotating vertical bars.
- pixel_data, out, COLOR_W: registered pixel colour.
- cfg_busy, out, 1: divider is recomputing bar geometry.
- mode_active, out, 2: mode currently in effect.

## Operation

**Palette.** Index 0..7 maps to white, black, red, green, blue, yellow, cyan, magenta. Channels are full-scale or zero in the selected format.

**Geometry FSM.** States are IDLE, DIV_H, DIV_V and RUN.
- Reset enters DIV_H.
- DIV_H computes bar_w = floor(h_disp / NUM_BARS) with an 11-step restoring divider, one bit per cycle.
- DIV_V then computes bar_h = floor(v_disp / NUM_BARS) the same way, then the FSM enters RUN.
- h_disp and v_disp are latched when DIV_H starts.
- In RUN, a difference between the inputs and the latched copies returns the FSM to DIV_H.
- A change during DIV_H or DIV_V restarts at DIV_H with the new values.
- cfg_busy is 1 in DIV_H and DIV_V.
- IDLE is entered only from RUN when h_disp = 0. It returns to DIV_H when h_disp becomes non-zero.

**Bar index.**
- Vertical: k = min(floor(xpos / bar_w), NUM_BARS-1).
- Horizontal: k = min(floor(ypos / bar_h), NUM_BARS-1).
- The last bar absorbs the remainder.
- A divisor of 0 (resolution < NUM_BARS) forces k = 0.
- Implementation uses a boundary counter reset on a data_req with xpos = 0 (vertical) or at a row start (horizontal), advanced by bar_w or bar_h. Within a line, xpos increments by 1 between consecutive requests.

**Modes.**
- 0: palette[k] from the vertical index.
- 1: palette[k] from the horizontal index.
- 2: white if bit CELL_LOG2 of xpos XOR bit CELL_LOG2 of ypos is 1, else black.
- 3: palette[(k + rot) mod 8] from the vertical index.

**Frame start and mode sampling.** Frame start is a data_req with xpos = 0 and ypos = 0. mode is sampled into mode_active only at frame start, so a mid-frame change never tears the pattern.

**Rotation counter.**
- frame_cnt counts frame starts from 0 to SCROLL_FRAMES-1.
- On wrap, rot increments mod 8.
- frame_cnt and rot run only while mode_active = 3 and clear when the mode leaves 3.

**Output update.** pixel_data updates only on data_req and holds otherwise. While cfg_busy = 1, pixel_data is black.

## Timing

- Reset values:
  - pixel_data = 0 (black).
  - cfg_busy = 1 (the FSM is in DIV_H).
  - mode_active = 0.
  - bar_w = 0, bar_h = 0.
  - frame_cnt = 0, rot = 0.
- Pixel latency is 1 cycle: pixel_data is valid on the edge after the data_req cycle.
- Geometry latency: cfg_busy falls 22 cycles after the FSM enters DIV_H (11 + 11), plus 1 cycle for the RUN transition. Total is 23 cycles from reset release or from the input change.
- A mode sampled at frame start applies to that same pixel (0,0).
- An asynchronous rst mid-division aborts it. Division restarts from DIV_H when rst releases.
- Frame start coinciding with a geometry restart: mode is still sampled, and the output stays black while busy.

## Configuration

- LCD_PATTERN_BORDER_EN defined: any pixel with xpos = 0, xpos = h_disp-1, ypos = 0 or ypos = v_disp-1 outputs white in every mode. It is still black while cfg_busy = 1.
- Undefined: no border logic; pixels follow the mode rules only.

## Test plan

- **Vertical bars, 480-wide.** Defaults, h_disp = 480, mode 0. Expect bar_w = 96. Pixels must be: x = 95 white, x = 96 black, x = 192 red, x = 479 blue (0x001F).
- **Remainder and zero divisor.** h_disp = 482, mode 0: x = 480 and x = 481 are blue. Then h_disp = 3 with NUM_BARS = 5: every pixel is white (k = 0).
- **Mode change mid-frame.** Change mode 0 to 1 at ypos = 100. The rest of the frame stays vertical bars. The next frame, with v_disp = 272 (bar_h = 54), has row 54 black and row 271 blue.
- **Rotation.** SCROLL_FRAMES = 2, mode 3. x = 0 is white for frames 0 and 1, black for frames 2 and 3, and white again after 16 frames.
- **Reset and re-divide.** Assert rst during DIV_H: pixel_data = 0 and cfg_busy = 1. After release, cfg_busy stays high exactly 23 cycles. A change of h_disp in RUN raises cfg_busy on the next cycle and outputs black while busy.
- **Border.** With LCD_PATTERN_BORDER_EN and mode 2, pixels (0,5), (479,5) and (5,271) are white. Without the macro, (0,5) is black with CELL_LOG2 = 5.
